// File: rtl/redun_mont_iter_ctrl.sv
// Sequencer for the redundant-form Montgomery squaring core: loads the core once,
// counts T squarings, captures the T-th result, flushes the core and reports done/err.
module redun_mont_iter_ctrl #(
  parameter int unsigned NUM_WRDS  = 64,
  parameter int unsigned WRD_BITS  = 16,
  parameter int unsigned T_BITS    = 32,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]     i_sq_init,
  input  logic [T_BITS-1:0]                    i_t,
  input  logic                                 i_abort,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [NUM_WRDS*(WRD_BITS+1)-1:0]     o_result,
  output logic [T_BITS-1:0]                    o_iter,
  output logic [NUM_WRDS*(WRD_BITS+1)-1:0]     o_core_sq,
  output logic                                 o_core_val,
  output logic                                 o_core_rst,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]     i_core_mul,
  input  logic                                 i_core_val
);

  localparam int unsigned BUS_W = NUM_WRDS * (WRD_BITS + 1);
  localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FL_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [T_BITS-1:0]  t_q;
  logic [T_BITS-1:0]  iter_q;
  logic [WD_W-1:0]    wd_q;
  logic [FL_W-1:0]    fcnt_q;
  logic               err_q;
  logic [BUS_W-1:0]   result_q;
  logic [BUS_W-1:0]   core_sq_q;
  logic               busy_q, done_q, core_val_q, core_rst_q;
  logic               busy_d, done_d, core_val_d, core_rst_d;

  logic               start_ok;
  logic               run_val;
  logic               last_val;
  logic               wd_expire;
  logic               flush_end;
  logic [T_BITS-1:0]  iter_inc;

  // The T-th valid takes priority over a coincident abort or watchdog expiry.
  assign start_ok  = ((state_q == S_IDLE) || (state_q == S_DONE)) && i_start;
  assign run_val   = (state_q == S_RUN) && i_core_val;
  assign last_val  = run_val && (iter_q == (t_q - T_BITS'(1)));
  assign wd_expire = (state_q == S_RUN) && !i_core_val && (wd_q == WD_W'(TIMEOUT - 2));
  assign flush_end = (fcnt_q == FL_W'(FLUSH_CYC - 1));
  assign iter_inc  = (iter_q == {T_BITS{1'b1}}) ? iter_q : (iter_q + T_BITS'(1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = (i_t != '0) ? S_LOAD : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: state_d = i_abort ? S_FLUSH : S_RUN;
      S_RUN: begin
        if (last_val || i_abort || wd_expire) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_end) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags come straight off flops
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    core_val_d = 1'b0;
    core_rst_d = 1'b0;
    unique case (state_d)
      S_LOAD: begin
        busy_d     = 1'b1;
        core_val_d = 1'b1;
      end
      S_RUN:   busy_d = 1'b1;
      S_FLUSH: begin
        busy_d     = 1'b1;
        core_rst_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_val_q <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_val_q <= core_val_d;
      core_rst_q <= core_rst_d;
    end
  end

  // Run datapath: latched request, iteration count, watchdog, flush timer, result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      t_q       <= '0;
      iter_q    <= '0;
      wd_q      <= '0;
      fcnt_q    <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      core_sq_q <= '0;
    end else begin
      fcnt_q <= (state_q == S_FLUSH) ? (fcnt_q + FL_W'(1)) : '0;

      if (start_ok) begin
        t_q    <= i_t;
        iter_q <= '0;
        err_q  <= 1'b0;
        if (i_t == '0) begin
          result_q <= i_sq_init;
        end else begin
          core_sq_q <= i_sq_init;
        end
      end

      if (state_q == S_LOAD) begin
        wd_q <= '0;
        if (i_abort) begin
          err_q <= 1'b1;
        end
      end

      if (state_q == S_RUN) begin
        if (i_core_val) begin
          iter_q <= iter_inc;
          wd_q   <= '0;
        end else begin
          wd_q <= wd_q + WD_W'(1);
        end
        if (last_val) begin
          result_q <= i_core_mul;
        end else if (i_abort || wd_expire) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_result   = result_q;
  assign o_iter     = iter_q;
  assign o_core_sq  = core_sq_q;
  assign o_core_val = core_val_q;
  assign o_core_rst = core_rst_q;

endmodule

// File: tb/tb_redun_mont_iter_ctrl.sv
// Randomized bench for redun_mont_iter_ctrl: a behavioural squaring core plus a
// per-run reference of expected result, iteration count, error flag and timing.
module tb_redun_mont_iter_ctrl;

  localparam int unsigned NW = 4;
  localparam int unsigned WB = 16;
  localparam int unsigned TB = 8;
  localparam int unsigned TO = 8;
  localparam int unsigned FC = 2;
  localparam int unsigned WW = WB + 1;
  localparam int unsigned BW = NW * WW;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [BW-1:0] i_sq_init;
  logic [TB-1:0] i_t;
  logic          i_abort;
  logic          o_busy, o_done, o_err, o_core_val, o_core_rst;
  logic [BW-1:0] o_result, o_core_sq;
  logic [TB-1:0] o_iter;
  logic [BW-1:0] i_core_mul;
  logic          i_core_val;

  redun_mont_iter_ctrl #(
    .NUM_WRDS(NW), .WRD_BITS(WB), .T_BITS(TB), .TIMEOUT(TO), .FLUSH_CYC(FC)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_sq_init(i_sq_init),
    .i_t(i_t), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_result(o_result), .o_iter(o_iter), .o_core_sq(o_core_sq),
    .o_core_val(o_core_val), .o_core_rst(o_core_rst),
    .i_core_mul(i_core_mul), .i_core_val(i_core_val)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [BW-1:0] prev_res = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-word stand-in for a Montgomery squaring: (w*w + 3) mod 2^(WB+1)
  function automatic logic [BW-1:0] sq(input logic [BW-1:0] x);
    logic [BW-1:0] r;
    longint unsigned a;
    r = '0;
    for (int i = 0; i < NW; i++) begin
      a = longint'(x[i*WW +: WW]);
      r[i*WW +: WW] = WW'((a * a + 64'd3) % (64'd1 << WW));
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] ref_pow(input logic [BW-1:0] x, input int t);
    logic [BW-1:0] v;
    v = x;
    for (int i = 0; i < t; i++) v = sq(v);
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*WW +: WW] = WW'($urandom);
    return v;
  endfunction

  // Behavioural core: latches the operand on the load strobe, then emits one
  // squaring every core_gap+1 cycles until core_stall results or a flush.
  int            core_gap = 1;
  int            core_stall = 0;
  bit            core_ign_rst = 1'b0;
  bit            core_active = 1'b0;
  int            core_cnt = 0;
  int            core_wait = 0;
  logic [BW-1:0] core_x = '0;

  initial begin
    i_core_val = 1'b0;
    i_core_mul = '0;
    forever begin
      @(posedge i_clk); #1;
      i_core_val = 1'b0;
      if (i_rst || (o_core_rst && !core_ign_rst)) begin
        core_active = 1'b0;
      end else if (o_core_val) begin
        core_x = o_core_sq; core_active = 1'b1; core_cnt = 0; core_wait = core_gap;
      end else if (core_active && core_cnt < core_stall) begin
        if (core_wait == 0) begin
          core_x = sq(core_x); i_core_mul = core_x; i_core_val = 1'b1;
          core_cnt++; core_wait = core_gap;
        end else begin
          core_wait--;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},    o_busy, 0);
    check_eq({tag, "_done"},    o_done, 0);
    check_eq({tag, "_err"},     o_err, 0);
    check_eq({tag, "_iter"},    o_iter, 0);
    check_eq({tag, "_result"},  o_result, 0);
    check_eq({tag, "_core_sq"}, o_core_sq, 0);
    check_eq({tag, "_core_val"}, o_core_val, 0);
    check_eq({tag, "_core_rst"}, o_core_rst, 0);
  endtask

  // One run. abort_at: -1 none, 0 during load, n>0 in the first idle cycle after n valids.
  task automatic do_run(input logic [BW-1:0] init, input int t, input int gap, input int stall,
                        input int abort_at, input bit abort_final, input bit poke, input bit ign);
    int s, load_cyc = -1, n_load = 0, vals = 0, m = -1, last_v, done_cyc = -1;
    int err_cyc = -1, rst_first = -1, rst_cnt = 0, busy_bad = 0, ab_cyc = -1, budget;
    bit normal, aborted = 1'b0;
    logic [BW-1:0] exp_res;
    int exp_iter;

    normal   = (abort_at < 0) && (stall >= t);
    exp_res  = normal ? ref_pow(init, t) : prev_res;
    exp_iter = normal ? t : ((abort_at >= 0) ? abort_at : stall);
    budget   = t * (gap + 1) + int'(TO) + int'(FC) + 10;

    @(posedge i_clk); #2;
    core_gap = gap; core_stall = stall; core_ign_rst = ign; core_active = 1'b0;
    i_start = 1'b1; i_sq_init = init; i_t = TB'(t); s = cyc;
    last_v = s + 1;

    for (int k = 0; k < budget && done_cyc < 0; k++) begin
      @(posedge i_clk); #2;
      i_start = 1'b0; i_abort = 1'b0; i_sq_init = rand_bus(); i_t = TB'($urandom);
      if (poke && k == 1) i_start = 1'b1;
      if (i_core_val) begin
        vals++; last_v = cyc;
        if (vals == t && m < 0) m = cyc;
      end
      if (abort_at == 0 && k == 0) begin
        i_abort = 1'b1; aborted = 1'b1; ab_cyc = cyc;
      end
      if (abort_at > 0 && !aborted && vals == abort_at && !i_core_val) begin
        i_abort = 1'b1; aborted = 1'b1; ab_cyc = cyc;
      end
      if (abort_final && i_core_val && vals == t) i_abort = 1'b1;
      @(negedge i_clk);
      if (o_core_val) begin
        n_load++; load_cyc = cyc;
        check_eq("core_sq_at_load", o_core_sq, init);
      end
      if (o_core_rst) begin
        rst_cnt++;
        if (rst_first < 0) rst_first = cyc;
      end
      if (o_err && err_cyc < 0) err_cyc = cyc;
      if (o_done) done_cyc = cyc;
      else if (!o_busy) busy_bad++;
    end

    if (done_cyc < 0) begin
      check_eq("done_within_budget", 0, 1);
    end else begin
      check_eq("busy_in_done", o_busy, 0);
      check_eq("err", o_err, !normal);
      check_eq("iter", o_iter, exp_iter);
      check_eq("result", o_result, exp_res);
      check_eq("busy_gaps", busy_bad, 0);
      if (t == 0) begin
        check_eq("t0_done_cyc", done_cyc, s + 1);
        check_eq("t0_no_load", n_load, 0);
        check_eq("t0_no_flush", rst_cnt, 0);
      end else begin
        check_eq("load_count", n_load, 1);
        check_eq("load_cyc", load_cyc, s + 1);
        check_eq("flush_len", rst_cnt, FC);
        check_eq("done_after_flush", done_cyc, rst_first + int'(FC));
        if (normal) begin
          check_eq("flush_start", rst_first, m + 1);
          check_eq("done_cyc", done_cyc, m + int'(FC) + 1);
        end else if (abort_at >= 0) begin
          check_eq("abort_err_cyc", err_cyc, ab_cyc + 1);
        end else begin
          check_eq("timeout_err_cyc", err_cyc, last_v + int'(TO));
        end
      end
      @(negedge i_clk);
      check_eq("done_one_cycle", o_done, 0);
      prev_res = exp_res;
    end
  endtask

  task automatic reset_mid_run();
    int seen_done = 0;
    logic [BW-1:0] init;
    init = rand_bus();
    @(posedge i_clk); #2;
    core_gap = 1; core_stall = 100; core_ign_rst = 1'b0; core_active = 1'b0;
    i_start = 1'b1; i_sq_init = init; i_t = TB'(10);
    @(posedge i_clk); #2;
    i_start = 1'b0;
    repeat (6) @(posedge i_clk);
    #2 i_rst = 1'b1;
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    @(negedge i_clk);
    check_idle_outputs("rst_mid");
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (o_done || o_busy) seen_done++;
    end
    check_eq("rst_mid_quiet", seen_done, 0);
    prev_res = '0;
  endtask

  initial begin
    int t, gap, sel, ab, stall;
    logic [BW-1:0] v;
    i_rst = 1'b1; i_start = 1'b0; i_sq_init = '0; i_t = '0; i_abort = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_idle_outputs("reset");
    @(posedge i_clk); #2;
    i_rst = 1'b0;

    v = BW'(5);
    do_run(v, 0, 1, 0, -1, 1'b0, 1'b0, 1'b0);               // T=0 passthrough
    do_run(rand_bus(), 1, 1, 100, -1, 1'b0, 1'b0, 1'b0);    // T=1, valid 2 cycles after load
    do_run(rand_bus(), 5, 2, 100, -1, 1'b0, 1'b0, 1'b0);    // T=5
    do_run(rand_bus(), 10, 1, 100, 3, 1'b0, 1'b0, 1'b0);    // abort after 3 valids
    do_run(rand_bus(), 4, 1, 2, -1, 1'b0, 1'b0, 1'b0);      // stall after 2 -> timeout
    do_run(rand_bus(), 3, 3, 0, -1, 1'b0, 1'b0, 1'b0);      // no valid at all -> timeout
    do_run(rand_bus(), 6, 1, 100, -1, 1'b0, 1'b1, 1'b0);    // start poked while busy
    do_run(rand_bus(), 3, 1, 100, -1, 1'b1, 1'b0, 1'b0);    // abort with final valid
    do_run(rand_bus(), 5, 2, 100, 0, 1'b0, 1'b0, 1'b0);     // abort during load
    do_run(rand_bus(), 4, 0, 7, -1, 1'b0, 1'b0, 1'b1);      // valids keep coming in flush
    do_run(rand_bus(), 255, 0, 300, -1, 1'b0, 1'b0, 1'b0);  // maximum T
    reset_mid_run();
    do_run(rand_bus(), 7, 1, 100, -1, 1'b0, 1'b0, 1'b0);    // fresh run after reset

    for (int r = 0; r < 16; r++) begin
      t     = $urandom_range(0, 12);
      gap   = $urandom_range(1, 3);
      sel   = (t == 0) ? 0 : $urandom_range(0, 3);
      ab    = -1;
      stall = 1000;
      if (sel == 1) ab = $urandom_range(0, t - 1);
      if (sel == 2) stall = $urandom_range(0, t - 1);
      if (sel == 0 && $urandom_range(0, 1) == 1) gap = 0;
      do_run(rand_bus(), t, gap, stall, ab, sel == 3, $urandom_range(0, 1) == 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit got=%0d exp=0", cyc);
    $fatal(1);
  end

endmodule
